// File: rtl/tmds_iddr_aligner.sv
// TMDS word aligner behind a 1:2 IDDR: packs bit pairs into 10-bit words and
// slips the extraction offset until the control tokens arrive back to back.
module tmds_iddr_aligner #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned SEARCH_WORDS = 64,
  parameter int unsigned LOSS_WORDS   = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] ddr_q,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       locked,
  output logic [3:0] slip_count,
  output logic       token_seen
);
  localparam int unsigned SR_W   = 20;
  localparam int unsigned WORD_W = 10;
  localparam int unsigned PH_W   = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TOK_W  = 8;
  localparam int unsigned SLIP_W = 4;

  localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(4);
  localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(9);
  localparam logic [CNT_W-1:0]  SEARCH_LAST = CNT_W'(SEARCH_WORDS - 1);
  localparam logic [CNT_W-1:0]  LOSS_LAST   = CNT_W'(LOSS_WORDS - 1);
  localparam logic [TOK_W-1:0]  LOCK_LAST   = TOK_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q;
  logic [PH_W-1:0]    phase_q;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [TOK_W-1:0]   tok_q, tok_d;
  logic [SLIP_W-1:0]  slip_d;
  logic               locked_d;
  logic [WORD_W-1:0]  window_c;
  logic               token_c;
  logic               extract_c;

  // Oldest bits sit at the low end of sr_q, so the offset selects from the bottom.
  assign window_c  = WORD_W'(sr_q >> slip_count);
  assign token_c   = (window_c == 10'h354) || (window_c == 10'h0AB) ||
                     (window_c == 10'h154) || (window_c == 10'h2AB);
  assign extract_c = (phase_q == PH_LAST);

  // Bit-pair shifter, word phase and registered word outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q       <= '0;
      phase_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      token_seen <= 1'b0;
    end else begin
      sr_q       <= {ddr_q[1], ddr_q[0], sr_q[SR_W-1:2]};
      phase_q    <= extract_c ? '0 : phase_q + PH_W'(1);
      word_valid <= extract_c;
      if (extract_c) begin
        word       <= window_c;
        token_seen <= token_c;
      end
    end
  end

  // Alignment FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_SEARCH;
      miss_q     <= '0;
      loss_q     <= '0;
      tok_q      <= '0;
      slip_count <= '0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_q     <= miss_d;
      loss_q     <= loss_d;
      tok_q      <= tok_d;
      slip_count <= slip_d;
      locked     <= locked_d;
    end
  end

  // Next-state logic; only extraction edges can move the FSM.
  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    loss_d   = loss_q;
    tok_d    = tok_q;
    slip_d   = slip_count;
    locked_d = locked;
    if (extract_c) begin
      case (state_q)
        S_SEARCH: begin
          if (token_c) begin
            miss_d = '0;
            if (LOCK_COUNT == 1) begin
              state_d  = S_LOCKED;
              locked_d = 1'b1;
              tok_d    = '0;
              loss_d   = '0;
            end else begin
              state_d = S_VERIFY;
              tok_d   = TOK_W'(1);
            end
          end else if (miss_q == SEARCH_LAST) begin
            miss_d = '0;
            slip_d = (slip_count == SLIP_MAX) ? '0 : slip_count + SLIP_W'(1);
          end else begin
            miss_d = miss_q + CNT_W'(1);
          end
        end
        S_VERIFY: begin
          if (!token_c) begin
            state_d = S_SEARCH;
            miss_d  = '0;
            tok_d   = '0;
          end else if (tok_q == LOCK_LAST) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            tok_d    = '0;
            loss_d   = '0;
          end else begin
            tok_d = tok_q + TOK_W'(1);
          end
        end
        S_LOCKED: begin
          if (token_c) begin
            loss_d = '0;
          end else if (loss_q == LOSS_LAST) begin
            state_d  = S_SEARCH;
            locked_d = 1'b0;
            miss_d   = '0;
            loss_d   = '0;
          end else begin
            loss_d = loss_q + CNT_W'(1);
          end
        end
        default: begin
          state_d  = S_SEARCH;
          locked_d = 1'b0;
          miss_d   = '0;
          loss_d   = '0;
          tok_d    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_iddr_aligner.sv
// Bench for tmds_iddr_aligner: serial-stream reference model, scenario table,
// directed multi-cycle sequences and a randomized token/data mix.
module tb_tmds_iddr_aligner;
  localparam int unsigned LOCK_N   = 4;
  localparam int unsigned SEARCH_N = 8;
  localparam int unsigned LOSS_N   = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [1:0] ddr_q = 2'b00;
  logic [9:0] word;
  logic       word_valid;
  logic       locked;
  logic [3:0] slip_count;
  logic       token_seen;

  always #5 clk = ~clk;

  tmds_iddr_aligner #(
    .LOCK_COUNT  (LOCK_N),
    .SEARCH_WORDS(SEARCH_N),
    .LOSS_WORDS  (LOSS_N)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ddr_q     (ddr_q),
    .word      (word),
    .word_valid(word_valid),
    .locked    (locked),
    .slip_count(slip_count),
    .token_seen(token_seen)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Stimulus: words serialized LSB first, placed so that offset drv_o extracts them.
  int         bitpos;
  int         drv_o;
  logic [9:0] cur_w;
  logic [9:0] fill_w;
  bit         rnd_mode;
  logic [9:0] wq[$];
  logic [9:0] toks[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic logic [9:0] rand_word();
    if ($urandom_range(0, 2) == 0) return toks[$urandom_range(0, 3)];
    return 10'($urandom);
  endfunction

  task automatic next_bit(output logic b);
    int idx;
    idx = (bitpos + 12 - drv_o) % 10;
    if (bitpos == 0 || idx == 0) begin
      if (wq.size() > 0) cur_w = wq.pop_front();
      else if (rnd_mode) cur_w = rand_word();
      else cur_w = fill_w;
    end
    b = cur_w[idx];
    bitpos++;
  endtask

  // Reference model: full serial history since reset, windows taken by index arithmetic.
  bit         hist[$];
  int         edge_n;
  int         m_state;  // 0 search, 1 verify, 2 locked
  int         m_miss, m_tok, m_loss, m_slip;
  logic       m_locked, m_tokseen, m_valid;
  logic [9:0] m_word;

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  task automatic model_reset();
    hist.delete();
    edge_n = 0; m_state = 0; m_miss = 0; m_tok = 0; m_loss = 0; m_slip = 0;
    m_locked = 1'b0; m_tokseen = 1'b0; m_valid = 1'b0; m_word = '0;
  endtask

  task automatic model_edge(input logic [1:0] q);
    int         start, idx;
    logic [9:0] w;
    bit         t;
    edge_n++;
    m_valid = 1'b0;
    if (edge_n % 5 == 0) begin
      // Word m (edge 5m) starts at serial bit 10m-22+offset; negative = reset zeros.
      start = 2 * edge_n - 22 + m_slip;
      for (int i = 0; i < 10; i++) begin
        idx  = start + i;
        w[i] = (idx < 0) ? 1'b0 : hist[idx];
      end
      t = is_tok(w);
      case (m_state)
        0: if (t) begin
             m_miss = 0; m_tok = 1;
             if (m_tok >= LOCK_N) begin m_state = 2; m_locked = 1'b1; m_tok = 0; m_loss = 0; end
             else m_state = 1;
           end else begin
             m_miss++;
             if (m_miss == SEARCH_N) begin m_miss = 0; m_slip = (m_slip + 1) % 10; end
           end
        1: if (t) begin
             m_tok++;
             if (m_tok == LOCK_N) begin m_state = 2; m_locked = 1'b1; m_tok = 0; m_loss = 0; end
           end else begin
             m_state = 0; m_miss = 0; m_tok = 0;
           end
        default: if (t) m_loss = 0;
           else begin
             m_loss++;
             if (m_loss == LOSS_N) begin m_state = 0; m_locked = 1'b0; m_miss = 0; m_loss = 0; end
           end
      endcase
      m_word = w; m_tokseen = t; m_valid = 1'b1;
    end
    hist.push_back(q[0]);
    hist.push_back(q[1]);
  endtask

  task automatic compare_outputs();
    check("word_valid", word_valid, m_valid);
    check("locked", locked, m_locked);
    check("slip_count", slip_count, m_slip);
    if (m_valid) begin
      check("word", word, m_word);
      check("token_seen", token_seen, m_tokseen);
    end
  endtask

  task automatic tick();
    logic b0, b1;
    @(posedge clk);
    if (resetn) model_edge(ddr_q);
    #1;
    if (resetn) compare_outputs();
    next_bit(b0);
    next_bit(b1);
    ddr_q = {b1, b0};
  endtask

  task automatic run_pulses(input int n);
    repeat (n) repeat (5) tick();
  endtask

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_word", word, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_slip_count", slip_count, 0);
      check("rst_token_seen", token_seen, 0);
      ddr_q = 2'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    model_reset();
    bitpos = 0; rnd_mode = 1'b0; wq.delete();
    hold_reset(n);
  endtask

  task automatic release_reset();
    logic b0, b1;
    @(negedge clk);
    next_bit(b0);
    next_bit(b1);
    ddr_q = {b1, b0};
    resetn = 1'b1;
  endtask

  typedef struct {
    int         o;
    logic [9:0] tok;
    int         pulses;
    int         exp_slip;
    bit         exp_locked;
    bit         chk_word;
  } row_t;

  row_t rows[5];

  initial begin
    int  cnt;
    bit  found;

    rows[0] = '{0, 10'h354, 10, 0, 1'b1, 1'b1};
    rows[1] = '{3, 10'h354, 30, 3, 1'b1, 1'b1};
    rows[2] = '{2, 10'h2AB, 22, 2, 1'b1, 1'b1};
    rows[3] = '{1, 10'h154, 14, 1, 1'b1, 1'b1};
    rows[4] = '{5, 10'h354, 36, 4, 1'b0, 1'b0};

    #2;
    do_reset(4);

    // Continuous token streams at various offsets.
    for (int r = 0; r < 5; r++) begin
      do_reset(1);
      drv_o = rows[r].o; fill_w = rows[r].tok;
      release_reset();
      run_pulses(rows[r].pulses);
      check($sformatf("row%0d_slip", r), slip_count, rows[r].exp_slip);
      check($sformatf("row%0d_locked", r), locked, rows[r].exp_locked);
      if (rows[r].chk_word) begin
        check($sformatf("row%0d_word", r), word, rows[r].tok);
        check($sformatf("row%0d_token_seen", r), token_seen, 1);
      end
    end

    // Reset asserted mid-search clears slip_count without a clock edge.
    do_reset(1);
    drv_o = 3; fill_w = 10'h354;
    release_reset();
    run_pulses(10);
    check("mid_pre_slip", slip_count, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_async_slip", slip_count, 0);
    check("mid_async_valid", word_valid, 0);
    check("mid_async_word", word, 0);
    model_reset();
    bitpos = 0; wq.delete();
    hold_reset(3);

    // VERIFY abort: two tokens, a data word, then tokens.
    do_reset(1);
    drv_o = 0; fill_w = 10'h354;
    wq.push_back(10'h354); wq.push_back(10'h354); wq.push_back(10'h1F0);
    release_reset();
    run_pulses(4);
    check("abort_data_word", word, 10'h1F0);
    check("abort_not_locked", locked, 0);
    run_pulses(3);
    check("abort_no_early_lock", locked, 0);
    run_pulses(1);
    check("abort_lock_4th", locked, 1);
    check("abort_slip", slip_count, 0);

    // Loss of lock: 31 misses, a token, then 32 misses and 8 more.
    do_reset(1);
    drv_o = 0; fill_w = 10'h354;
    release_reset();
    run_pulses(6);
    check("loss_initial_lock", locked, 1);
    repeat (31) wq.push_back(10'h1F0);
    wq.push_back(10'h0AB);
    repeat (32) wq.push_back(10'h1F0);
    fill_w = 10'h1F0;
    found = 1'b0;
    for (int k = 0; k < 45 && !found; k++) begin
      run_pulses(1);
      if (word == 10'h0AB) found = 1'b1;
    end
    check("loss_token_reached", found, 1);
    check("loss_held_at_token", locked, 1);
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      run_pulses(1);
      cnt++;
      if (!locked) found = 1'b1;
    end
    check("loss_fall_count", cnt, 32);
    check("loss_fall_word", word, 10'h1F0);
    run_pulses(7);
    check("loss_no_slip_yet", slip_count, 0);
    run_pulses(1);
    check("loss_slip_after_8", slip_count, 1);

    // Offset wrap: reach slip 9 on idle data, then a stream needing offset 2.
    do_reset(1);
    drv_o = 2; fill_w = 10'h000;
    release_reset();
    run_pulses(72);
    check("wrap_at_9", slip_count, 9);
    fill_w = 10'h2AB;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      run_pulses(1);
      if (slip_count == 4'd0) found = 1'b1;
    end
    check("wrap_to_0", found, 1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      run_pulses(1);
      if (locked) found = 1'b1;
    end
    check("wrap_locked", found, 1);
    check("wrap_slip", slip_count, 2);
    check("wrap_word", word, 10'h2AB);

    // Randomized token/data mix at a random alignment.
    for (int r = 0; r < 2; r++) begin
      do_reset(1);
      drv_o = int'($urandom_range(0, 9));
      rnd_mode = 1'b1;
      release_reset();
      run_pulses(300);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
